error_output_logic: RTL and testbench

- Serialises test-status reports into a byte stream for a downstream UART transmitter.
- On a loop-complete event it emits a short "L" record. On an error event it emits an "E" record carrying the captured error state, address, expected data and actual data.
- Sits between the memory-test engine (event source) and the UART TX byte interface (ready/accepted handshake).

---
 rtl/error_output_logic.sv | 151 +++++++++++++++
 tb/tb_error_output_logic.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/error_output_logic.sv
// Serialises loop-complete and error events into 'L'/'E' byte records for a UART TX handshake.
// Optional 24-bit loop counter in the 'L' record: define ERROR_OUTPUT_LOOP_COUNT_EN.
module error_output_logic #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  loop_complete,
  input  logic                  error_detected,
  input  logic [7:0]            error_state,
  input  logic [ADDR_WIDTH-1:0] error_address,
  input  logic [DATA_WIDTH-1:0] expected_data,
  input  logic [DATA_WIDTH-1:0] actual_data,
  input  logic                  tx_data_accepted,
  output logic                  tx_data_ready,
  output logic [7:0]            tx_data
);

  localparam int unsigned ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int unsigned DATA_BYTES = (DATA_WIDTH + 7) / 8;
  localparam int unsigned ADDR_PAD_W = ADDR_BYTES * 8;
  localparam int unsigned DATA_PAD_W = DATA_BYTES * 8;
  localparam int unsigned ERR_LEN    = 4 + ADDR_BYTES + 2 * DATA_BYTES;
  localparam int unsigned LOOP_LEN   = 6;
  localparam int unsigned MAX_LEN    = (ERR_LEN > LOOP_LEN) ? ERR_LEN : LOOP_LEN;
  localparam int unsigned IDX_W      = $clog2(MAX_LEN);
  localparam int unsigned ERR_W      = ERR_LEN * 8;
  localparam int unsigned LOOP_W     = LOOP_LEN * 8;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    LOAD,
    SEND,
    GAP
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    cap_is_err;
  logic [7:0]              cap_state;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   cap_exp;
  logic [DATA_WIDTH-1:0]   cap_act;

  logic                    loop_take_c;
  logic [23:0]             loop_field_c;
  logic [ERR_W-1:0]        err_rec_c;
  logic [LOOP_W-1:0]       loop_rec_c;
  logic [7:0]              cur_byte_c;
  logic                    last_c;

  assign loop_take_c = (state == IDLE) && loop_complete && !error_detected;

`ifdef ERROR_OUTPUT_LOOP_COUNT_EN
  logic [23:0] loop_cnt;
  logic [23:0] loop_cap;

  // Report the pre-increment count; wraps naturally at 2^24
  always_ff @(posedge clk) begin
    if (rst) begin
      loop_cnt <= 24'h0;
      loop_cap <= 24'h0;
    end else if (loop_take_c) begin
      loop_cap <= loop_cnt;
      loop_cnt <= loop_cnt + 24'd1;
    end
  end

  assign loop_field_c = loop_cap;
`else
  assign loop_field_c = 24'h0;
`endif

  // Records laid out byte 0 at the LSB so idx selects bytes in transmit order
  assign err_rec_c  = {8'h0A, 8'h0D, DATA_PAD_W'(cap_act), DATA_PAD_W'(cap_exp),
                       ADDR_PAD_W'(cap_addr), cap_state, 8'h45};
  assign loop_rec_c = {8'h0A, 8'h0D, loop_field_c, 8'h4C};

  always_comb begin
    cur_byte_c = 8'h00;
    for (int i = 0; i < ERR_LEN; i++) begin
      if (cap_is_err && (idx == IDX_W'(i))) cur_byte_c = err_rec_c[i*8 +: 8];
    end
    for (int i = 0; i < LOOP_LEN; i++) begin
      if (!cap_is_err && (idx == IDX_W'(i))) cur_byte_c = loop_rec_c[i*8 +: 8];
    end
  end

  assign last_c = cap_is_err ? (idx == IDX_W'(ERR_LEN - 1)) : (idx == IDX_W'(LOOP_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      cap_is_err    <= 1'b0;
      cap_state     <= 8'h00;
      cap_addr      <= '0;
      cap_exp       <= '0;
      cap_act       <= '0;
      tx_data_ready <= 1'b0;
      tx_data       <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (error_detected || loop_complete) begin
            cap_is_err <= error_detected;
            cap_state  <= error_state;
            cap_addr   <= error_address;
            cap_exp    <= expected_data;
            cap_act    <= actual_data;
            state      <= CAPTURE;
          end
        end
        CAPTURE: begin
          idx   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          tx_data_ready <= 1'b1;
          tx_data       <= cur_byte_c;
          state         <= SEND;
        end
        SEND: begin
          if (tx_data_accepted) begin
            tx_data_ready <= 1'b0;
            tx_data       <= 8'h00;
            if (last_c) begin
              state <= IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= GAP;
            end
          end
        end
        GAP: begin
          tx_data_ready <= 1'b1;
          tx_data       <= cur_byte_c;
          state         <= SEND;
        end
        default: begin
          tx_data_ready <= 1'b0;
          tx_data       <= 8'h00;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_error_output_logic.sv
// Directed self-checking bench for error_output_logic (default parameters).
// Loop-count expectations follow ERROR_OUTPUT_LOOP_COUNT_EN when defined.
module tb_error_output_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic       loop_complete;
  logic       error_detected;
  logic [7:0] error_state;
  logic [9:0] error_address;
  logic [0:0] expected_data;
  logic [0:0] actual_data;
  logic       tx_data_accepted;
  logic       tx_data_ready;
  logic [7:0] tx_data;

  int errors = 0;
  int checks = 0;

  error_output_logic #(.ADDR_WIDTH(10), .DATA_WIDTH(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .loop_complete   (loop_complete),
    .error_detected  (error_detected),
    .error_state     (error_state),
    .error_address   (error_address),
    .expected_data   (expected_data),
    .actual_data     (actual_data),
    .tx_data_accepted(tx_data_accepted),
    .tx_data_ready   (tx_data_ready),
    .tx_data         (tx_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; loop_complete = 1'b0; error_detected = 1'b0; error_state = 8'h00;
    error_address = 10'h000; expected_data = 1'b0; actual_data = 1'b0; tx_data_accepted = 1'b0;
    tick();
    checks++;
    if (tx_data_ready !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_during: ready=%b data=%02h, required ready=0 data=00", tx_data_ready, tx_data);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (tx_data_ready !== 1'b0 || tx_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_after[%0d]: ready=%b data=%02h, required ready=0 data=00", k, tx_data_ready, tx_data);
      end
    end
  endtask

  task automatic test_loop_record();
    logic [7:0] exp_b [6];
    exp_b = '{8'h4C, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h0A};
    loop_complete = 1'b1; tx_data_accepted = 1'b0;
    tick();                                   // trigger edge N
    loop_complete = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (tx_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL loop_latency[%0d]: ready=%b, required ready=0", k, tx_data_ready);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin         // after N+2 and N+3, held while not accepted
      checks++;
      if (tx_data_ready !== 1'b1 || tx_data !== 8'h4C) begin
        errors++;
        $display("FAIL loop_first[%0d]: ready=%b data=%02h, required ready=1 data=4c", k, tx_data_ready, tx_data);
      end
      if (k == 0) tick();
    end
    tx_data_accepted = 1'b1;
    tick();                                   // transfer of 'L'
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (tx_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL loop_gap[%0d]: ready=%b, required ready=0", i, tx_data_ready);
      end
      tick();
      checks++;
      if (tx_data_ready !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++;
        $display("FAIL loop_byte[%0d]: ready=%b data=%02h, required ready=1 data=%02h", i, tx_data_ready, tx_data, exp_b[i]);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL loop_tail[%0d]: ready=%b, required ready=0", k, tx_data_ready);
      end
      tick();
    end
  endtask

  task automatic test_error_record();
    logic [7:0] exp_b [8];
    exp_b = '{8'h45, 8'h02, 8'hEF, 8'h03, 8'h01, 8'h00, 8'h0D, 8'h0A};
    error_detected = 1'b1; error_state = 8'h02; error_address = 10'h3EF;
    expected_data = 1'b1; actual_data = 1'b0; tx_data_accepted = 1'b1;
    tick();
    // Scramble inputs: the record must use the values captured on the trigger edge
    error_detected = 1'b0; error_state = 8'hFF; error_address = 10'h000;
    expected_data = 1'b0; actual_data = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_data_ready !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++;
        $display("FAIL err_byte[%0d]: ready=%b data=%02h, required ready=1 data=%02h", i, tx_data_ready, tx_data, exp_b[i]);
      end
      tick();
      checks++;
      if (tx_data_ready !== 1'b0 || tx_data !== 8'h00) begin
        errors++;
        $display("FAIL err_gap[%0d]: ready=%b data=%02h, required ready=0 data=00", i, tx_data_ready, tx_data);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tx_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL err_tail[%0d]: ready=%b, required ready=0", k, tx_data_ready);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [8];
    exp_b = '{8'h45, 8'h5A, 8'h55, 8'h01, 8'h00, 8'h01, 8'h0D, 8'h0A};
    error_detected = 1'b1; error_state = 8'h5A; error_address = 10'h155;
    expected_data = 1'b0; actual_data = 1'b1; tx_data_accepted = 1'b1;
    tick();
    error_detected = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_data_ready !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++;
        $display("FAIL bp_byte[%0d]: ready=%b data=%02h, required ready=1 data=%02h", i, tx_data_ready, tx_data, exp_b[i]);
      end
      if (i == 2) begin
        tx_data_accepted = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick();
          checks++;
          if (tx_data_ready !== 1'b1 || tx_data !== 8'h55) begin
            errors++;
            $display("FAIL bp_hold[%0d]: ready=%b data=%02h, required ready=1 data=55", k, tx_data_ready, tx_data);
          end
        end
        tx_data_accepted = 1'b1;
      end
      tick();
      tick();
    end
    checks++;
    if (tx_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_tail: ready=%b, required ready=0", tx_data_ready);
    end
  endtask

  task automatic test_priority_and_ignore();
    logic [7:0] exp_b [8];
    exp_b = '{8'h45, 8'h11, 8'h00, 8'h00, 8'h01, 8'h01, 8'h0D, 8'h0A};
    error_detected = 1'b1; loop_complete = 1'b1; error_state = 8'h11; error_address = 10'h000;
    expected_data = 1'b1; actual_data = 1'b1; tx_data_accepted = 1'b1;
    tick();
    error_detected = 1'b0; loop_complete = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_data_ready !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++;
        $display("FAIL prio_byte[%0d]: ready=%b data=%02h, required ready=1 data=%02h", i, tx_data_ready, tx_data, exp_b[i]);
      end
      if (i == 3) begin
        error_detected = 1'b1; loop_complete = 1'b1;
      end
      tick();
      error_detected = 1'b0; loop_complete = 1'b0;
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tx_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_tail[%0d]: ready=%b, required ready=0", k, tx_data_ready);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_record();
    logic [7:0] exp_b [8];
    error_detected = 1'b1; error_state = 8'h02; error_address = 10'h3EF;
    expected_data = 1'b1; actual_data = 1'b0; tx_data_accepted = 1'b1;
    tick();
    error_detected = 1'b0;
    for (int k = 0; k < 8; k++) tick();       // now presenting byte 3
    checks++;
    if (tx_data_ready !== 1'b1 || tx_data !== 8'h03) begin
      errors++;
      $display("FAIL midrst_pre: ready=%b data=%02h, required ready=1 data=03", tx_data_ready, tx_data);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (tx_data_ready !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_abort: ready=%b data=%02h, required ready=0 data=00", tx_data_ready, tx_data);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (tx_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL midrst_idle[%0d]: ready=%b, required ready=0", k, tx_data_ready);
      end
    end
    exp_b = '{8'h45, 8'h7E, 8'hA5, 8'h02, 8'h01, 8'h00, 8'h0D, 8'h0A};
    error_detected = 1'b1; error_state = 8'h7E; error_address = 10'h2A5;
    expected_data = 1'b1; actual_data = 1'b0;
    tick();
    error_detected = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_data_ready !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++;
        $display("FAIL midrst_fresh[%0d]: ready=%b data=%02h, required ready=1 data=%02h", i, tx_data_ready, tx_data, exp_b[i]);
      end
      tick();
      tick();
    end
    checks++;
    if (tx_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_tail: ready=%b, required ready=0", tx_data_ready);
    end
  endtask

  // Two loop records after a reset: counts 0 then 1 with the counter, 0 and 0 without
  task automatic test_loop_count();
    logic [7:0] exp_b [6];
    logic [7:0] second_c;
`ifdef ERROR_OUTPUT_LOOP_COUNT_EN
    second_c = 8'h01;
`else
    second_c = 8'h00;
`endif
    tx_data_accepted = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_b = '{8'h4C, (r == 0) ? 8'h00 : second_c, 8'h00, 8'h00, 8'h0D, 8'h0A};
      loop_complete = 1'b1;
      tick();
      loop_complete = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (tx_data_ready !== 1'b1 || tx_data !== exp_b[i]) begin
          errors++;
          $display("FAIL cnt_rec%0d_byte[%0d]: ready=%b data=%02h, required ready=1 data=%02h", r, i, tx_data_ready, tx_data, exp_b[i]);
        end
        tick();
        tick();
      end
      checks++;
      if (tx_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL cnt_rec%0d_tail: ready=%b, required ready=0", r, tx_data_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loop_record();
    test_error_record();
    test_backpressure();
    test_priority_and_ignore();
    test_reset_mid_record();
    test_loop_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
